// File: rtl/hack_pkg.sv
// rtl/hack_pkg.sv - shared types and constants for the HACK instruction-memory loader
package hack_pkg;

    typedef enum logic [2:0] {
        HDR_HI,
        HDR_LO,
        DAT_HI,
        DAT_LO,
        HOLD,
        RUN,
        ERR
    } loader_state_t;

    localparam int WORD_W             = 16;
    localparam int PC_W               = 15;
    localparam int DEFAULT_ADDR_W     = 14;
    localparam int DEFAULT_RESET_HOLD = 2;

endpackage

// File: rtl/hack_irom.sv
// rtl/hack_irom.sv - 2**ADDR_W x 16 instruction RAM, posedge write, negedge registered read
module hack_irom
    import hack_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [0:(1 << ADDR_W)-1];

    // Contents intentionally survive reset so a partial or aborted load keeps earlier words.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/hack_rom_loader.sv
// rtl/hack_rom_loader.sv - byte-stream program loader holding the HACK core in reset until loaded
module hack_rom_loader
    import hack_pkg::*;
#(
    parameter int ADDR_W     = DEFAULT_ADDR_W,
    parameter int RESET_HOLD = DEFAULT_RESET_HOLD
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              load_req,
    input  logic [PC_W-1:0]   pc,
    output logic [WORD_W-1:0] inst,
    output logic              cpu_reset,
    output logic              loading,
    output logic              error,
    output logic [PC_W-1:0]   words_loaded
);

    localparam logic [16:0] DEPTH     = 17'(1 << ADDR_W);
    localparam logic [7:0]  HOLD_LAST = 8'((RESET_HOLD > 0) ? RESET_HOLD - 1 : 0);

    loader_state_t state;
    logic [15:0]   n_words;
    logic [7:0]    hi_byte;
    logic [7:0]    hold_cnt;
    logic          accept;
    logic          we;
    logic [15:0]   next_count;
    logic [15:0]   hdr_count;
    logic          unused_pc;

    assign rx_ready   = (state == HDR_HI) || (state == HDR_LO) ||
                        (state == DAT_HI) || (state == DAT_LO);
    assign accept     = rx_valid && rx_ready;
    assign we         = accept && (state == DAT_LO);
    assign next_count = {1'b0, words_loaded} + 16'd1;
    assign hdr_count  = {n_words[15:8], rx_data};
    assign unused_pc  = ^pc;

    hack_irom #(
        .ADDR_W(ADDR_W)
    ) u_irom (
        .clk   (clk),
        .reset (reset),
        .we    (we),
        .waddr (words_loaded[ADDR_W-1:0]),
        .wdata ({hi_byte, rx_data}),
        .raddr (pc[ADDR_W-1:0]),
        .rdata (inst)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= HDR_HI;
            n_words      <= '0;
            hi_byte      <= '0;
            hold_cnt     <= '0;
            words_loaded <= '0;
            cpu_reset    <= 1'b1;
            loading      <= 1'b1;
            error        <= 1'b0;
        end else begin
            case (state)
                HDR_HI: begin
                    if (accept) begin
                        n_words[15:8] <= rx_data;
                        state         <= HDR_LO;
                    end
                end
                HDR_LO: begin
                    if (accept) begin
                        n_words[7:0] <= rx_data;
                        hold_cnt     <= '0;
                        if (hdr_count == 16'd0) begin
                            state <= HOLD;
                        end else if ({1'b0, hdr_count} > DEPTH) begin
                            state   <= ERR;
                            error   <= 1'b1;
                            loading <= 1'b0;
                        end else begin
                            state <= DAT_HI;
                        end
                    end
                end
                DAT_HI: begin
                    if (accept) begin
                        hi_byte <= rx_data;
                        state   <= DAT_LO;
                    end
                end
                DAT_LO: begin
                    if (accept) begin
                        words_loaded <= next_count[PC_W-1:0];
                        hold_cnt     <= '0;
                        state        <= (next_count == n_words) ? HOLD : DAT_HI;
                    end
                end
                HOLD: begin
                    if (hold_cnt >= HOLD_LAST) begin
                        state     <= RUN;
                        cpu_reset <= 1'b0;
                        loading   <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                RUN: begin
                    if (load_req) begin
                        state        <= HDR_HI;
                        cpu_reset    <= 1'b1;
                        loading      <= 1'b1;
                        words_loaded <= '0;
                    end
                end
                ERR: begin
                    if (load_req) begin
                        state        <= HDR_HI;
                        error        <= 1'b0;
                        loading      <= 1'b1;
                        words_loaded <= '0;
                    end
                end
                default: state <= HDR_HI;
            endcase
        end
    end

endmodule

// File: doc/hack_rom_loader.md
Name: hack_rom_loader

Overview:
- Upstream instruction-memory stage for the HACK CPU.
- Receives a program as a byte stream (e.g. from a UART receiver) and writes it into an on-chip 16-bit instruction memory.
- Holds the CPU in reset while loading, then releases it.
- Serves `inst` from `pc` with the falling-edge synchronous read timing the HACK core expects.

Parameters:
- ADDR_W, 14, instruction memory address width; depth = 2**ADDR_W words; `pc` is indexed by its low ADDR_W bits.
- RESET_HOLD, 2, number of clk cycles `cpu_reset` stays high after the last word is written, before the CPU runs.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- rx_data  input  8  incoming program byte
- rx_valid  input  1  rx_data is valid this cycle
- rx_ready  output  1  loader accepts a byte this cycle; a byte transfers when rx_valid && rx_ready at posedge
- load_req  input  1  single-cycle pulse requesting a reload from RUN or ERR
- pc  input  15  CPU program counter
- inst  output  16  instruction at pc, updated on negedge clk
- cpu_reset  output  1  reset to the HACK core
- loading  output  1  high in the HDR_*/DAT_*/HOLD states
- error  output  1  high in ERR
- words_loaded  output  15  count of words written in the current load

Behaviour:
- One clock (clk); reset is asynchronous and active-high; all flops clear on reset assertion.
- Reset values:
  - state = HDR_HI
  - cpu_reset = 1, loading = 1, error = 0
  - words_loaded = 0, inst = 0
  - rx_ready = 1 after reset deasserts
  - Memory contents are not cleared.
- Stream format, all big-endian:
  - Header: 16-bit word count N.
  - Then N instruction words, each sent as 2 bytes, high byte first.
- State machine (transitions only on an accepted byte unless noted):
  - HDR_HI: latch N[15:8] -> HDR_LO.
  - HDR_LO: latch N[7:0], then:
    - N == 0 -> HOLD; existing memory is kept.
    - N > 2**ADDR_W -> ERR.
    - otherwise -> DAT_HI.
  - DAT_HI: latch high byte -> DAT_LO.
  - DAT_LO: in the same posedge, write {hi, byte} to mem[words_loaded] and increment words_loaded.
    - If the new words_loaded == N -> HOLD; else -> DAT_HI.
  - HOLD: rx_ready = 0; counts RESET_HOLD cycles with cpu_reset = 1, then -> RUN.
  - RUN: cpu_reset = 0, loading = 0, rx_ready = 0. On load_req -> HDR_HI: cpu_reset = 1 on the next posedge, words_loaded = 0.
  - ERR: error = 1, cpu_reset = 1, rx_ready = 0. On load_req -> HDR_HI with error cleared; otherwise sticky until reset.
- rx_ready = 1 exactly in HDR_HI, HDR_LO, DAT_HI, DAT_LO.
  - Bytes with rx_valid while rx_ready = 0 are dropped; there is no buffering.
- load_req is ignored in the loading states (HDR_*, DAT_*, HOLD).
- Instruction read:
  - inst <= mem[pc[ADDR_W-1:0]] on every negedge clk, in all states; pc bits above ADDR_W are ignored.
  - A word written at posedge is readable at the following negedge. Write-then-read of the same address in one cycle returns the new data.
- Reset asserted mid-load: the FSM returns to HDR_HI immediately. Already-written words persist; the partial load is not reported.
- cpu_reset is a registered output and is glitch-free.

Decomposition:
- Package hack_pkg:
  - loader state enum (HDR_HI, HDR_LO, DAT_HI, DAT_LO, HOLD, RUN, ERR)
  - WORD_W = 16, PC_W = 15
  - default ADDR_W/RESET_HOLD constants
- Sub-module hack_irom: single-port-write / single-port-read RAM, 2**ADDR_W x 16. Write on posedge with we/waddr/wdata; registered read on negedge from raddr. This keeps BRAM inference isolated.
- hack_rom_loader: FSM, byte assembly, counters, cpu_reset generation.

Test Plan:
- Basic load: reset 2 cycles, stream 00 02 | 00 05 | EC 10, back-to-back valid -> mem[0] = 0x0005, mem[1] = 0xEC10, words_loaded = 2. cpu_reset falls exactly RESET_HOLD = 2 cycles after the DAT_LO accept. With pc = 1, inst = 0xEC10 at the next negedge.
- Gapped input: same stream with rx_valid low for 3 cycles between every byte -> identical memory contents and cpu_reset timing relative to the last byte.
- Zero count: stream 00 00 after a prior load -> no writes, old contents intact, cpu_reset low 2 cycles after HDR_LO accept.
- Oversize: stream 40 01 (16385 > 16384) -> error = 1, cpu_reset = 1, rx_ready = 0. Further bytes are ignored. load_req pulse -> error = 0, rx_ready = 1.
- Reload from RUN: in RUN pulse load_req -> cpu_reset = 1 next cycle, words_loaded = 0. Load 00 01 | 7F FF -> mem[0] = 0x7FFF, CPU released again.
- Async reset mid-load: assert reset between the DAT_HI and DAT_LO bytes of word 3 -> all outputs at reset values immediately, without a clock edge. Words 0-1 remain in memory, and the next byte is treated as HDR_HI.
